// File: rtl/decode_pkg.sv
// Shared RV32I decode types: opcodes, control flags, immediate formats and the queued bundle.
// Used by rv32i_field_decoder and decode_issue_queue.
package decode_pkg;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
    localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

    typedef enum logic [2:0] {
        FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SH, FMT_NONE
    } imm_fmt_t;

    typedef struct packed {
        logic illegal, dren, dwen, branch, jump, wen;
        logic csr_swap, csr_set, csr_clr, csr_imm;
        logic ecall, breakpoint, ret, wfi, ifence, halt;
    } dec_ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        dec_ctrl_t   ctrl;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } dec_bundle_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] i, input imm_fmt_t f);
        logic [31:0] r;
        case (f)
            FMT_I:   r = {{20{i[31]}}, i[31:20]};
            FMT_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
            FMT_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            FMT_U:   r = {i[31:12], 12'h000};
            FMT_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            FMT_SH:  r = {27'h0, i[24:20]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rv32i_field_decoder.sv
// Combinational RV32I word -> decoded bundle fields (flags, register indices, immediate).
// Illegal words keep only ctrl.illegal set and carry a zero immediate.
module rv32i_field_decoder
    import decode_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR = 32'h0000_006F
) (
    input  logic [31:0] instr_i,
    output dec_bundle_t bundle_o
);

    dec_ctrl_t  ctrl;
    imm_fmt_t   fmt;
    logic       legal;
    logic       writes;
    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];

    always_comb begin
        ctrl   = '0;
        fmt    = FMT_NONE;
        legal  = 1'b1;
        writes = 1'b0;
        unique case (instr_i[6:0])
            OP_LOAD: begin
                fmt       = FMT_I;
                writes    = 1'b1;
                ctrl.dren = 1'b1;
                legal     = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OP_STORE: begin
                fmt       = FMT_S;
                ctrl.dwen = 1'b1;
                legal     = f3 inside {3'b000, 3'b001, 3'b010};
            end
            OP_BRANCH: begin
                fmt         = FMT_B;
                ctrl.branch = 1'b1;
                legal       = !(f3 inside {3'b010, 3'b011});
            end
            OP_JAL: begin
                fmt       = FMT_J;
                writes    = 1'b1;
                ctrl.jump = 1'b1;
            end
            OP_JALR: begin
                fmt       = FMT_I;
                writes    = 1'b1;
                ctrl.jump = 1'b1;
                legal     = (f3 == 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                fmt    = FMT_U;
                writes = 1'b1;
            end
            OP_IMM: begin
                fmt    = FMT_I;
                writes = 1'b1;
                if (f3 == 3'b001) begin
                    fmt   = FMT_SH;
                    legal = (f7 == 7'b0000000);
                end else if (f3 == 3'b101) begin
                    fmt   = FMT_SH;
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                end
            end
            OP_OP: begin
                writes = 1'b1;
                legal  = (f7 == 7'b0000000) ||
                         ((f7 == 7'b0100000) && (f3 == 3'b000 || f3 == 3'b101));
            end
            OP_MISC_MEM: begin
                fmt         = FMT_I;
                ctrl.ifence = (f3 == 3'b001);
                legal       = (f3 == 3'b000) || (f3 == 3'b001);
            end
            OP_SYSTEM: begin
                fmt = FMT_I;
                if (f3 == 3'b000) begin
                    unique case (1'b1)
                        (instr_i == INSTR_ECALL):  ctrl.ecall      = 1'b1;
                        (instr_i == INSTR_EBREAK): ctrl.breakpoint = 1'b1;
                        (instr_i == INSTR_MRET):   ctrl.ret        = 1'b1;
                        (instr_i == INSTR_WFI):    ctrl.wfi        = 1'b1;
                        default:                   legal           = 1'b0;
                    endcase
                end else begin
                    writes        = 1'b1;
                    legal         = (f3 != 3'b100);
                    ctrl.csr_swap = (f3[1:0] == 2'b01);
                    ctrl.csr_set  = (f3[1:0] == 2'b10);
                    ctrl.csr_clr  = (f3[1:0] == 2'b11);
                    ctrl.csr_imm  = f3[2];
                end
            end
            default: legal = 1'b0;
        endcase
        ctrl.wen = writes && (instr_i[11:7] != 5'd0);
        if (instr_i == HALT_INSTR) begin
            ctrl.halt = 1'b1;
            ctrl.jump = 1'b1;
        end
        if (!legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
            fmt          = FMT_NONE;
        end
    end

    always_comb begin
        bundle_o       = '0;
        bundle_o.instr = instr_i;
        bundle_o.ctrl  = ctrl;
        bundle_o.rd    = instr_i[11:7];
        bundle_o.rs1   = instr_i[19:15];
        bundle_o.rs2   = instr_i[24:20];
        bundle_o.imm   = gen_imm(instr_i, fmt);
    end

endmodule

// File: rtl/decode_issue_queue.sv
// Registered RV32I decode plus decoded-bundle FIFO between fetch and execute.
// Optional DECODE_BYPASS_EN: empty queue forwards the decoded input straight to out_*.
module decode_issue_queue
    import decode_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter int          PC_W       = 32,
    parameter logic [31:0] HALT_INSTR = 32'h0000_006F
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output dec_ctrl_t                out_ctrl,
    output logic [4:0]               out_rd,
    output logic [4:0]               out_rs1,
    output logic [4:0]               out_rs2,
    output logic [31:0]              out_imm,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    dec_bundle_t            mem_q [DEPTH];
    logic [PC_W-1:0]        pc_q  [DEPTH];
    logic [AW:0]            wr_ptr_q, rd_ptr_q, count_q, count_d;
    dec_bundle_t            dec, head;
    logic [PC_W-1:0]        head_pc;
    logic                   empty, full, byp, push, pop;

    rv32i_field_decoder #(.HALT_INSTR(HALT_INSTR)) u_dec (
        .instr_i  (in_instr),
        .bundle_o (dec)
    );

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef DECODE_BYPASS_EN
    assign byp = empty && in_valid && out_ready && !flush;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = !full;
    assign push      = in_valid && in_ready && !flush && !byp;
    assign pop       = !empty && out_ready && !flush;
    assign out_valid = !empty || byp;

    assign head    = byp ? dec   : mem_q[rd_ptr_q[AW-1:0]];
    assign head_pc = byp ? in_pc : pc_q[rd_ptr_q[AW-1:0]];

    assign out_pc    = head_pc;
    assign out_instr = head.instr;
    assign out_ctrl  = head.ctrl;
    assign out_rd    = head.rd;
    assign out_rs1   = head.rs1;
    assign out_rs2   = head.rs2;
    assign out_imm   = head.imm;
    assign count     = count_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + ONE;
            2'b01:   count_d = count_q - ONE;
            default: count_d = count_q;
        endcase
    end

    // Flush resets the pointers only; stale storage is unreachable afterwards.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= dec;
                pc_q[wr_ptr_q[AW-1:0]]  <= in_pc;
                wr_ptr_q                <= wr_ptr_q + ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ONE;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue with a scoreboard of expected bundles.
// Expected bundles are queued on accepted pushes and compared on each pop.
module tb_decode_issue_queue;
    import decode_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        dec_ctrl_t   ctrl;
        logic [31:0] imm;
    } exp_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    dec_ctrl_t   out_ctrl;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [2:0]  count;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    dec_ctrl_t   exp_c = '0;
    logic [31:0] exp_imm = '0;

    decode_issue_queue dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_ctrl(out_ctrl),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_imm(out_imm), .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input logic [31:0] ins, input logic [31:0] pc,
                       input dec_ctrl_t c, input logic [31:0] imm);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        exp_c    = c;
        exp_imm  = imm;
    endtask

    function automatic dec_ctrl_t cw();
        dec_ctrl_t c = '0;
        c.wen = 1'b1;
        return c;
    endfunction

    task automatic put_addi(input int k, input logic [31:0] pc);
        put((32'(k) << 20) | (32'(k) << 7) | 32'h13, pc, cw(), 32'(k));
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            if (flush) begin
                sb.delete();
            end else begin
                if (in_valid && in_ready)
                    sb.push_back('{pc: in_pc, instr: in_instr, ctrl: exp_c, imm: exp_imm});
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL sb_underflow got_pc=%h exp=none", out_pc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("pop_pc", out_pc, e.pc);
                        chk("pop_instr", out_instr, e.instr);
                        chk("pop_ctrl", 32'(out_ctrl), 32'(e.ctrl));
                        chk("pop_rd", 32'(out_rd), 32'(e.instr[11:7]));
                        chk("pop_rs1", 32'(out_rs1), 32'(e.instr[19:15]));
                        chk("pop_rs2", 32'(out_rs2), 32'(e.instr[24:20]));
                        chk("pop_imm", out_imm, e.imm);
                    end
                end
            end
        end
    end

    initial begin
        dec_ctrl_t c;

        // reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_ctrl", 32'(out_ctrl), 0);
        nRST = 1'b1;
        tick();

        // single addi, one-cycle latency
        put(32'h0050_0093, 32'h100, cw(), 32'd5);
        chk("t1_same_cycle_valid", 32'(out_valid), 0);
        tick();
        in_valid = 1'b0;
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_rd", 32'(out_rd), 1);
        chk("t1_imm", out_imm, 5);
        chk("t1_wen", 32'(out_ctrl.wen), 1);
        chk("t1_count", 32'(count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_count_after_pop", 32'(count), 0);
        chk("t1_valid_after_pop", 32'(out_valid), 0);

        // fill to full, refuse 5th, drain in order
        for (int k = 0; k < 4; k++) begin
            put_addi(k + 1, 32'h200 + 32'(k * 4));
            tick();
            chk("t2_fill_count", 32'(count), 32'(k + 1));
        end
        chk("t2_full_in_ready", 32'(in_ready), 0);
        put_addi(9, 32'h210);
        tick();
        chk("t2_refused_count", 32'(count), 4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        chk("t2_drained_count", 32'(count), 0);

        // full push+pop refuses push; non-full push+pop keeps count
        for (int k = 0; k < 4; k++) begin
            put_addi(k + 10, 32'h300 + 32'(k * 4));
            tick();
        end
        put_addi(20, 32'h320);
        out_ready = 1'b1;
        tick();
        chk("t3_full_pushpop_count", 32'(count), 3);
        for (int k = 0; k < 3; k++) begin
            put_addi(k + 21, 32'h330 + 32'(k * 4));
            tick();
            chk("t3_pushpop_count", 32'(count), 3);
        end
        in_valid = 1'b0;
        repeat (3) tick();
        out_ready = 1'b0;
        chk("t3_drained_count", 32'(count), 0);

        // flush with queued entries and a pending input
        for (int k = 0; k < 3; k++) begin
            put_addi(k + 5, 32'h400 + 32'(k * 4));
            tick();
        end
        put_addi(30, 32'h40C);
        out_ready = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("t4_flush_count", 32'(count), 0);
        chk("t4_flush_valid", 32'(out_valid), 0);
        tick();
        chk("t4_word_dropped", 32'(count), 0);

        // decode vectors streamed through the queue
        out_ready = 1'b1;
        put(32'hFFF0_0113, 32'h500, cw(), 32'hFFFF_FFFF); tick();
        c = '0; c.branch = 1'b1;
        put(32'hFE00_0EE3, 32'h504, c, 32'hFFFF_FFFC); tick();
        c = '0; c.dwen = 1'b1;
        put(32'hFE11_2E23, 32'h508, c, 32'hFFFF_FFFC); tick();
        put(32'hABCD_E2B7, 32'h50C, cw(), 32'hABCD_E000); tick();
        c = cw(); c.jump = 1'b1;
        put(32'hFF9F_F0EF, 32'h510, c, 32'hFFFF_FFF8); tick();
        put(32'h01F0_9193, 32'h514, cw(), 32'h0000_001F); tick();
        put(32'h41F0_D193, 32'h518, cw(), 32'h0000_001F); tick();
        c = '0; c.illegal = 1'b1;
        put(32'h41F0_9193, 32'h51C, c, 32'h0); tick();
        put(32'hFFFF_FFFF, 32'h520, c, 32'h0); tick();
        put(32'h0000_0012, 32'h524, c, 32'h0); tick();
        c = '0; c.halt = 1'b1; c.jump = 1'b1;
        put(32'h0000_006F, 32'h528, c, 32'h0); tick();
        c = cw(); c.dren = 1'b1;
        put(32'h0000_2083, 32'h52C, c, 32'h0); tick();
        c = '0; c.csr_swap = 1'b1;
        put(32'h3402_9073, 32'h530, c, 32'h0000_0340); tick();
        c = '0; c.ret = 1'b1;
        put(32'h3020_0073, 32'h534, c, 32'h0000_0302); tick();
        c = '0; c.ifence = 1'b1;
        put(32'h0000_100F, 32'h538, c, 32'h0); tick();
        in_valid = 1'b0;
        repeat (2) tick();
        out_ready = 1'b0;
        chk("t5_drained_count", 32'(count), 0);

        // empty-queue latency (bypass vs registered)
        out_ready = 1'b1;
        put(32'h0070_0393, 32'h600, cw(), 32'd7);
`ifdef DECODE_BYPASS_EN
        chk("t6_same_cycle_valid", 32'(out_valid), 1);
        chk("t6_same_cycle_imm", out_imm, 7);
`else
        chk("t6_same_cycle_valid", 32'(out_valid), 0);
`endif
        tick();
        in_valid = 1'b0;
`ifdef DECODE_BYPASS_EN
        chk("t6_count", 32'(count), 0);
        chk("t6_next_valid", 32'(out_valid), 0);
`else
        chk("t6_count", 32'(count), 1);
        chk("t6_next_valid", 32'(out_valid), 1);
`endif
        tick();
        out_ready = 1'b0;
        chk("t6_final_count", 32'(count), 0);

        // asynchronous reset mid-operation
        put_addi(3, 32'h700);
        tick();
        put_addi(4, 32'h704);
        tick();
        in_valid = 1'b0;
        chk("t7_pre_reset_count", 32'(count), 2);
        #1;
        nRST = 1'b0;
        #1;
        chk("t7_reset_count", 32'(count), 0);
        chk("t7_reset_valid", 32'(out_valid), 0);
        chk("t7_reset_in_ready", 32'(in_ready), 1);
        sb.delete();
        tick();
        nRST = 1'b1;
        tick();
        chk("t7_after_reset_valid", 32'(out_valid), 0);

        chk("sb_empty_at_end", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
